// File: rtl/slc3_bus_pkg.sv
// Shared bus definitions for the SLC-3 datapath: lane select encoding and lane count.
package slc3_bus_pkg;

  typedef enum logic [1:0] {LANE00, LANE01, LANE10, LANE11} lane_sel_t;

  localparam int NUM_LANES = 4;

endpackage

// File: rtl/demux_lane.sv
// One-entry output buffer for a single demux lane; free means it can take a word this cycle.
module demux_lane #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data_out,
  output logic             free
);

  logic             full;
  logic [width-1:0] buf_q;

  // A full lane whose consumer is ready empties at this edge, so it may refill at the same time.
  assign free     = ~full | ready;
  assign valid    = full;
  assign data_out = buf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full  <= 1'b0;
      buf_q <= '0;
    end else if (load) begin
      full  <= 1'b1;
      buf_q <= data_in;
    end else if (full && ready) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_buf.sv
// 1-to-4 valid/ready demultiplexer with a one-word buffer per lane.
// Optional broadcast to all four lanes is enabled by defining DEMUX_BCAST_EN.
module demux1to4_buf
  import slc3_bus_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [width-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] d00,
  output logic [width-1:0] d01,
  output logic [width-1:0] d10,
  output logic [width-1:0] d11,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_BCAST_EN
  ,
  input  logic             in_bcast
`endif
);

  lane_sel_t            sel;
  logic                 bcast;
  logic                 accept;
  logic [NUM_LANES-1:0] free;
  logic [NUM_LANES-1:0] load;
  logic [width-1:0]     lane_data [NUM_LANES];

  assign sel = lane_sel_t'(in_sel);

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A broadcast word is only taken when every lane can absorb it on the same edge.
  assign in_ready = bcast ? &free : free[sel];
  assign accept   = in_valid & in_ready;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    assign load[n] = accept & (bcast | (in_sel == 2'(n)));

    demux_lane #(.width(width)) u_lane (
      .clk      (Clk),
      .reset    (Reset),
      .load     (load[n]),
      .data_in  (in_data),
      .ready    (out_ready[n]),
      .valid    (out_valid[n]),
      .data_out (lane_data[n]),
      .free     (free[n])
    );
  end

  assign d00 = lane_data[0];
  assign d01 = lane_data[1];
  assign d10 = lane_data[2];
  assign d11 = lane_data[3];

endmodule

// File: tb/tb_demux1to4_buf.sv
// Self-checking bench for demux1to4_buf: directed vector table, hand sequences and a random run
// against a per-lane occupancy model. Broadcast cases are included when DEMUX_BCAST_EN is defined.
module tb_demux1to4_buf;

  logic        Clk;
  logic        Reset;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d00, d01, d10, d11;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        in_bcast;

  int checks = 0;
  int errors = 0;

  demux1to4_buf #(.width(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d00       (d00),
    .d01       (d01),
    .d10       (d10),
    .d11       (d11),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_BCAST_EN
    ,
    .in_bcast  (in_bcast)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  ordy;
    logic        chk_rdy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    int          chk_lane;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs [9];

  // Occupancy model: each lane holds at most one word.
  int          mcnt [4];
  logic [15:0] mval [4];

  function automatic logic [15:0] laneData(int n);
    case (n)
      0:       return d00;
      1:       return d01;
      2:       return d10;
      default: return d11;
    endcase
  endfunction

  task automatic applyStimulus(input logic rst, input logic vld, input logic [1:0] sel,
                               input logic [15:0] data, input logic [3:0] ordy, input logic bc);
    Reset     = rst;
    in_valid  = vld;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
    in_bcast  = bc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic        rrst, rvld, rbc, exp_rdy;
    logic [1:0]  rsel;
    logic [15:0] rdata;
    logic [3:0]  rordy, exp_ov;

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'hF, 1'b0);

    vecs[0] = '{1'b1, 1'b1, 2'd0, 16'hFFFF, 4'hF, 1'b0, 1'b0, 4'h0, 0,  16'h0000};
    vecs[1] = '{1'b1, 1'b1, 2'd3, 16'hEEEE, 4'hF, 1'b1, 1'b1, 4'h0, 3,  16'h0000};
    vecs[2] = '{1'b0, 1'b1, 2'd2, 16'h1234, 4'hF, 1'b1, 1'b1, 4'h4, 2,  16'h1234};
    vecs[3] = '{1'b0, 1'b0, 2'd2, 16'h0000, 4'hF, 1'b1, 1'b1, 4'h0, -1, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 2'd0, 16'hAAAA, 4'hE, 1'b1, 1'b1, 4'h1, 0,  16'hAAAA};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 16'hBBBB, 4'hE, 1'b1, 1'b0, 4'h1, 0,  16'hAAAA};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 16'h5555, 4'hE, 1'b1, 1'b1, 4'h9, 3,  16'h5555};
    vecs[7] = '{1'b0, 1'b1, 2'd0, 16'hBBBB, 4'hF, 1'b1, 1'b1, 4'h1, 0,  16'hBBBB};
    vecs[8] = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 1'b1, 4'h0, -1, 16'h0000};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy, 1'b0);
      #1;
      if (vecs[i].chk_rdy)
        checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk_lane >= 0)
        checkOutput($sformatf("vec%0d_lane%0d_data", i, vecs[i].chk_lane),
                    32'(laneData(vecs[i].chk_lane)), 32'(vecs[i].exp_d));
    end

    // Back-to-back round-robin stream: one word per cycle, each lane sees its words in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'(i % 4), 16'h0100 + 16'(i), 4'hF, 1'b0);
      #1;
      checkOutput($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      checkOutput($sformatf("rr%0d_out_valid", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
      checkOutput($sformatf("rr%0d_data", i), 32'(laneData(i % 4)), 32'(16'h0100 + 16'(i)));
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'hF, 1'b0);
    tick();
    checkOutput("rr_drained", 32'(out_valid), 32'h0);

`ifdef DEMUX_BCAST_EN
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h1111, 4'hD, 1'b0);
    #1;
    checkOutput("bc_fill_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("bc_fill_out_valid", 32'(out_valid), 32'h2);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hC3C3, 4'hD, 1'b1);
    #1;
    checkOutput("bc_blocked_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("bc_blocked_out_valid", 32'(out_valid), 32'h2);
    checkOutput("bc_blocked_d01", 32'(d01), 32'h1111);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hC3C3, 4'hF, 1'b1);
    #1;
    checkOutput("bc_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("bc_out_valid", 32'(out_valid), 32'hF);
    for (int n = 0; n < 4; n++)
      checkOutput($sformatf("bc_lane%0d_data", n), 32'(laneData(n)), 32'hC3C3);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'hF, 1'b0);
    tick();
`endif

    // Random traffic against the occupancy model, with occasional mid-stream resets.
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'h0, 1'b0);
    tick();
    for (int n = 0; n < 4; n++) begin
      mcnt[n] = 0;
      mval[n] = '0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rrst  = ($urandom_range(63) == 0);
      rvld  = ($urandom_range(3) != 0);
      rsel  = 2'($urandom_range(3));
      rdata = 16'($urandom);
      rordy = 4'($urandom);
      rbc   = 1'b0;
`ifdef DEMUX_BCAST_EN
      rbc   = ($urandom_range(7) == 0);
`endif
      applyStimulus(rrst, rvld, rsel, rdata, rordy, rbc);
      #1;
      if (rbc) begin
        exp_rdy = 1'b1;
        for (int n = 0; n < 4; n++)
          if (mcnt[n] == 1 && !rordy[n]) exp_rdy = 1'b0;
      end else begin
        exp_rdy = (mcnt[rsel] == 0) || rordy[rsel];
      end
      checkOutput($sformatf("rnd%0d_in_ready", cyc), 32'(in_ready), 32'(exp_rdy));
      tick();

      if (rrst) begin
        for (int n = 0; n < 4; n++) mcnt[n] = 0;
      end else begin
        for (int n = 0; n < 4; n++)
          if (mcnt[n] == 1 && rordy[n]) mcnt[n] = 0;
        if (rvld && exp_rdy) begin
          for (int n = 0; n < 4; n++)
            if (rbc || rsel == 2'(n)) begin
              mcnt[n] = 1;
              mval[n] = rdata;
            end
        end
      end

      exp_ov = '0;
      for (int n = 0; n < 4; n++) exp_ov[n] = (mcnt[n] == 1);
      checkOutput($sformatf("rnd%0d_out_valid", cyc), 32'(out_valid), 32'(exp_ov));
      for (int n = 0; n < 4; n++)
        if (mcnt[n] == 1)
          checkOutput($sformatf("rnd%0d_lane%0d_data", cyc, n), 32'(laneData(n)), 32'(mval[n]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
